// File: rtl/pcie_dma_pkg.sv
// Shared PCIe endpoint types: TLP fmt/type codes, RX parser states
// and the completion request handed from the RX to the TX engine.
package pcie_dma_pkg;

  localparam logic [7:0] PCIE_FMT_TYPE_MRD32 = {3'b000, 5'b00000};
  localparam logic [7:0] PCIE_FMT_TYPE_MRD64 = {3'b001, 5'b00000};
  localparam logic [7:0] PCIE_FMT_TYPE_MWR32 = {3'b010, 5'b00000};
  localparam logic [7:0] PCIE_FMT_TYPE_MWR64 = {3'b011, 5'b00000};

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD32,
    ST_RD64,
    ST_WR32,
    ST_WR64,
    ST_WR64_DATA,
    ST_WAIT_WR,
    ST_WAIT_CPL,
    ST_DISCARD
  } pcie_rx_state_t;

  typedef struct packed {
    logic [2:0]  tc;
    logic [1:0]  attr;
    logic [15:0] rid;
    logic [7:0]  tag;
    logic [6:0]  laddr;
  } pcie_compl_req_t;

endpackage

// File: rtl/pcie_io_ep_rx_engine.sv
// RX TLP parser: single-DW MRd/MWr (32/64-bit addressing) into the
// endpoint memory write port and a completion request to the TX engine.
module pcie_io_ep_rx_engine
  import pcie_dma_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic [63:0] i_rx_tdata,
  input  logic [7:0]  i_rx_tkeep,
  input  logic        i_rx_tlast,
  input  logic        i_rx_tvalid,
  output logic        o_rx_tready,
  output logic [10:0] o_wr_addr,
  output logic [3:0]  o_wr_be,
  output logic [31:0] o_wr_data,
  output logic        o_wr_en,
  input  logic        i_wr_busy,
  output logic [10:0] o_rd_addr,
  output logic [3:0]  o_rd_be,
  output logic        o_req_compl,
  output logic [2:0]  o_req_tc,
  output logic [1:0]  o_req_attr,
  output logic [15:0] o_req_rid,
  output logic [7:0]  o_req_tag,
  output logic [6:0]  o_req_laddr,
  input  logic        i_compl_done
);

  pcie_rx_state_t  state_q, state_d, dec;
  pcie_compl_req_t hdr_q, hdr_d;
  pcie_compl_req_t req_q, req_d;
  logic [3:0]  fbe_q, fbe_d;
  logic [10:0] addr_q, addr_d;
  logic        tready_q, tready_d;
  logic [10:0] wr_addr_q, wr_addr_d;
  logic [3:0]  wr_be_q, wr_be_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        wr_en_q, wr_en_d;
  logic [10:0] rd_addr_q, rd_addr_d;
  logic [3:0]  rd_be_q, rd_be_d;
  logic        compl_q, compl_d;
  logic        hs, is_wr, drop;
  logic [7:0]  ft;

  // tkeep is implied by the single-DW-only support
  logic unused_bits;
  assign unused_bits = ^{i_rx_tkeep, i_rx_tdata};

  assign hs = i_rx_tvalid && tready_q;
  assign ft = {1'b0, i_rx_tdata[30:24]};

  always_comb begin
    dec   = ST_DISCARD;
    is_wr = 1'b0;
    case (ft)
      PCIE_FMT_TYPE_MRD32: dec = ST_RD32;
      PCIE_FMT_TYPE_MRD64: dec = ST_RD64;
      PCIE_FMT_TYPE_MWR32: begin
        dec   = ST_WR32;
        is_wr = 1'b1;
      end
      PCIE_FMT_TYPE_MWR64: begin
        dec   = ST_WR64;
        is_wr = 1'b1;
      end
      default: dec = ST_DISCARD;
    endcase
    drop = (i_rx_tdata[9:0] != 10'd1) ||
           (is_wr && i_rx_tdata[14]);
  end

  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    req_d     = req_q;
    fbe_d     = fbe_q;
    addr_d    = addr_q;
    wr_addr_d = wr_addr_q;
    wr_be_d   = wr_be_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_be_d   = rd_be_q;
    compl_d   = compl_q;
    case (state_q)
      ST_IDLE: if (hs) begin
        hdr_d.tc    = i_rx_tdata[22:20];
        hdr_d.attr  = i_rx_tdata[13:12];
        hdr_d.rid   = i_rx_tdata[63:48];
        hdr_d.tag   = i_rx_tdata[47:40];
        hdr_d.laddr = 7'd0;
        fbe_d       = i_rx_tdata[35:32];
        if (i_rx_tlast)
          state_d = ST_IDLE;
        else if (drop)
          state_d = ST_DISCARD;
        else
          state_d = dec;
      end
      ST_RD32: if (hs) begin
        rd_addr_d   = i_rx_tdata[12:2];
        rd_be_d     = fbe_q;
        req_d       = hdr_q;
        req_d.laddr = {i_rx_tdata[6:2], 2'b00};
        compl_d     = 1'b1;
        state_d     = ST_WAIT_CPL;
      end
      ST_RD64: if (hs) begin
        rd_addr_d   = i_rx_tdata[44:34];
        rd_be_d     = fbe_q;
        req_d       = hdr_q;
        req_d.laddr = {i_rx_tdata[38:34], 2'b00};
        compl_d     = 1'b1;
        state_d     = ST_WAIT_CPL;
      end
      ST_WR32: if (hs) begin
        wr_addr_d = i_rx_tdata[12:2];
        wr_data_d = i_rx_tdata[63:32];
        wr_be_d   = fbe_q;
        wr_en_d   = 1'b1;
        state_d   = ST_WAIT_WR;
      end
      ST_WR64: if (hs) begin
        addr_d  = i_rx_tdata[44:34];
        state_d = i_rx_tlast ? ST_IDLE : ST_WR64_DATA;
      end
      ST_WR64_DATA: if (hs) begin
        wr_addr_d = addr_q;
        wr_data_d = i_rx_tdata[31:0];
        wr_be_d   = fbe_q;
        wr_en_d   = 1'b1;
        state_d   = ST_WAIT_WR;
      end
      // busy echoes the strobe one cycle later, then falls
      ST_WAIT_WR: if (!wr_en_q || i_wr_busy) state_d = ST_IDLE;
      ST_WAIT_CPL: if (i_compl_done) begin
        compl_d = 1'b0;
        state_d = ST_IDLE;
      end
      ST_DISCARD: if (hs && i_rx_tlast) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    tready_d = !(state_d == ST_WAIT_WR || state_d == ST_WAIT_CPL);
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q   <= ST_IDLE;
      hdr_q     <= '0;
      req_q     <= '0;
      fbe_q     <= '0;
      addr_q    <= '0;
      tready_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_be_q   <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_be_q   <= '0;
      compl_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_q     <= hdr_d;
      req_q     <= req_d;
      fbe_q     <= fbe_d;
      addr_q    <= addr_d;
      tready_q  <= tready_d;
      wr_addr_q <= wr_addr_d;
      wr_be_q   <= wr_be_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      rd_addr_q <= rd_addr_d;
      rd_be_q   <= rd_be_d;
      compl_q   <= compl_d;
    end
  end

  assign o_rx_tready = tready_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_be     = wr_be_q;
  assign o_wr_data   = wr_data_q;
  assign o_wr_en     = wr_en_q;
  assign o_rd_addr   = rd_addr_q;
  assign o_rd_be     = rd_be_q;
  assign o_req_compl = compl_q;
  assign o_req_tc    = req_q.tc;
  assign o_req_attr  = req_q.attr;
  assign o_req_rid   = req_q.rid;
  assign o_req_tag   = req_q.tag;
  assign o_req_laddr = req_q.laddr;

endmodule

// File: tb/tb_pcie_io_ep_rx_engine.sv
// Bench for pcie_io_ep_rx_engine: table of TLPs, write/completion
// scoreboards and a delayed completion responder.
module tb_pcie_io_ep_rx_engine;

  localparam int CPL_DLY = 10;

  logic        i_clk = 1'b0;
  logic        i_nrst = 1'b0;
  logic [63:0] i_rx_tdata = '0;
  logic [7:0]  i_rx_tkeep = 8'hFF;
  logic        i_rx_tlast = 1'b0;
  logic        i_rx_tvalid = 1'b0;
  logic        o_rx_tready;
  logic [10:0] o_wr_addr;
  logic [3:0]  o_wr_be;
  logic [31:0] o_wr_data;
  logic        o_wr_en;
  logic        i_wr_busy;
  logic [10:0] o_rd_addr;
  logic [3:0]  o_rd_be;
  logic        o_req_compl;
  logic [2:0]  o_req_tc;
  logic [1:0]  o_req_attr;
  logic [15:0] o_req_rid;
  logic [7:0]  o_req_tag;
  logic [6:0]  o_req_laddr;
  logic        i_compl_done = 1'b0;

  pcie_io_ep_rx_engine dut (
    .i_clk(i_clk), .i_nrst(i_nrst),
    .i_rx_tdata(i_rx_tdata), .i_rx_tkeep(i_rx_tkeep),
    .i_rx_tlast(i_rx_tlast), .i_rx_tvalid(i_rx_tvalid),
    .o_rx_tready(o_rx_tready),
    .o_wr_addr(o_wr_addr), .o_wr_be(o_wr_be),
    .o_wr_data(o_wr_data), .o_wr_en(o_wr_en),
    .i_wr_busy(i_wr_busy),
    .o_rd_addr(o_rd_addr), .o_rd_be(o_rd_be),
    .o_req_compl(o_req_compl), .o_req_tc(o_req_tc),
    .o_req_attr(o_req_attr), .o_req_rid(o_req_rid),
    .o_req_tag(o_req_tag), .o_req_laddr(o_req_laddr),
    .i_compl_done(i_compl_done)
  );

  always #5 i_clk = ~i_clk;

  // memory busy flag: registered copy of the write strobe
  always @(posedge i_clk or negedge i_nrst)
    if (!i_nrst) i_wr_busy <= 1'b0;
    else         i_wr_busy <= o_wr_en;

  typedef struct packed {
    logic [2:0][63:0] b;
    logic [1:0]  nb_m1;
    logic        is_wr;
    logic        is_rd;
    logic [10:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [2:0]  tc;
    logic [1:0]  attr;
    logic [15:0] rid;
    logic [7:0]  tag;
    logic [6:0]  laddr;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t wr_q[$];
  vec_t rd_q[$];
  vec_t tv[10];
  vec_t cur;
  bit   compl_seen = 0;
  int   cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] hdr(
    input logic [1:0] fmt, input logic [4:0] typ,
    input logic [2:0] tc, input logic ep, input logic [1:0] attr,
    input logic [9:0] len, input logic [15:0] rid,
    input logic [7:0] tag, input logic [3:0] fbe);
    return {rid, tag, 4'h0, fbe, 1'b0, fmt, typ, 1'b0, tc,
            4'h0, 1'b0, ep, attr, 2'b00, len};
  endfunction

  function automatic vec_t mkv(
    input logic [63:0] b0, input logic [63:0] b1,
    input logic [63:0] b2, input int nb,
    input logic w, input logic r, input logic [10:0] a,
    input logic [3:0] be, input logic [31:0] d,
    input logic [2:0] tc, input logic [1:0] attr,
    input logic [15:0] rid, input logic [7:0] tag,
    input logic [6:0] la);
    vec_t v;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2;
    v.nb_m1 = 2'(nb - 1);
    v.is_wr = w; v.is_rd = r;
    v.addr = a; v.be = be; v.data = d;
    v.tc = tc; v.attr = attr; v.rid = rid;
    v.tag = tag; v.laddr = la;
    return v;
  endfunction

  // scoreboard monitor plus delayed completion responder
  always @(negedge i_clk) begin
    if (!i_nrst) begin
      compl_seen = 0;
      i_compl_done = 1'b0;
    end else if (i_compl_done) begin
      i_compl_done = 1'b0;
      chk("compl_cleared", o_req_compl, 1'b0);
    end else if (o_req_compl) begin
      if (!compl_seen) begin
        compl_seen = 1;
        cnt = 0;
        if (rd_q.size() == 0) begin
          chk("unexpected_compl", 1'b1, 1'b0);
        end else begin
          cur = rd_q.pop_front();
          chk("rd_addr", o_rd_addr, cur.addr);
          chk("rd_be", o_rd_be, cur.be);
          chk("req_tc", o_req_tc, cur.tc);
          chk("req_attr", o_req_attr, cur.attr);
          chk("req_rid", o_req_rid, cur.rid);
          chk("req_tag", o_req_tag, cur.tag);
          chk("req_laddr", o_req_laddr, cur.laddr);
        end
      end else begin
        cnt++;
        if (cnt == CPL_DLY) begin
          chk("rd_addr_held", o_rd_addr, cur.addr);
          chk("req_tag_held", o_req_tag, cur.tag);
          i_compl_done = 1'b1;
        end
      end
    end else begin
      compl_seen = 0;
    end
    if (i_nrst && o_wr_en) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_wr_en", 1'b1, 1'b0);
      end else begin
        vec_t e;
        e = wr_q.pop_front();
        chk("wr_addr", o_wr_addr, e.addr);
        chk("wr_be", o_wr_be, e.be);
        chk("wr_data", o_wr_data, e.data);
      end
    end
  end

  // called and returns at a falling edge
  task automatic send_beat(input logic [63:0] d, input logic last);
    int n;
    n = 0;
    i_rx_tvalid = 1'b1;
    i_rx_tdata  = d;
    i_rx_tlast  = last;
    while (!o_rx_tready && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 50) chk("beat_accept_timeout", 1'b0, 1'b1);
    @(negedge i_clk);
    i_rx_tvalid = 1'b0;
    i_rx_tlast  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    if (v.is_wr) wr_q.push_back(v);
    if (v.is_rd) rd_q.push_back(v);
    for (int k = 0; k <= int'(v.nb_m1); k++)
      send_beat(v.b[k], k == int'(v.nb_m1));
    if (v.is_wr) begin
      chk("wr_stall1_tready", o_rx_tready, 1'b0);
      @(negedge i_clk);
      chk("wr_stall2_tready", o_rx_tready, 1'b0);
      @(negedge i_clk);
      chk("wr_resume_tready", o_rx_tready, 1'b1);
    end else if (v.is_rd) begin
      chk("rd_compl_rise", o_req_compl, 1'b1);
      n = 0;
      while (o_req_compl && n < 100) begin
        @(negedge i_clk);
        n++;
      end
      chk("rd_done_timeout", n < 100, 1'b1);
      chk("rd_resume_tready", o_rx_tready, 1'b1);
    end else begin
      chk("discard_tready", o_rx_tready, 1'b1);
      chk("discard_no_compl", o_req_compl, 1'b0);
    end
    @(negedge i_clk);
    chk("sb_empty", wr_q.size() + rd_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tv[0] = mkv(hdr(2'b10, 5'd0, 3'd0, 1'b0, 2'd0, 10'd1,
                    16'h0000, 8'h00, 4'hF),
                {32'hDEADBEEF, 32'h0000_0104}, 64'h0, 2,
                1, 0, 11'h041, 4'hF, 32'hDEADBEEF,
                3'd0, 2'd0, 16'h0, 8'h0, 7'h0);
    tv[1] = mkv(hdr(2'b00, 5'd0, 3'd2, 1'b0, 2'd1, 10'd1,
                    16'h0100, 8'h2A, 4'h3),
                {32'h0, 32'h0000_1FFC}, 64'h0, 2,
                0, 1, 11'h7FF, 4'h3, 32'h0,
                3'd2, 2'd1, 16'h0100, 8'h2A, 7'h7C);
    tv[2] = mkv(hdr(2'b11, 5'd0, 3'd0, 1'b0, 2'd0, 10'd1,
                    16'h0000, 8'h00, 4'hC),
                {32'h0000_2008, 32'h0000_0001},
                {32'h0, 32'hCAFEF00D}, 3,
                1, 0, 11'h002, 4'hC, 32'hCAFEF00D,
                3'd0, 2'd0, 16'h0, 8'h0, 7'h0);
    tv[3] = mkv(hdr(2'b01, 5'd0, 3'd7, 1'b0, 2'd2, 10'd1,
                    16'hBEEF, 8'h55, 4'hF),
                {32'h0000_0ABC, 32'h0000_0005}, 64'h0, 2,
                0, 1, 11'h2AF, 4'hF, 32'h0,
                3'd7, 2'd2, 16'hBEEF, 8'h55, 7'h3C);
    tv[4] = mkv(hdr(2'b10, 5'd0, 3'd0, 1'b0, 2'd0, 10'd2,
                    16'h0, 8'h0, 4'hF),
                {32'h11111111, 32'h0000_0010},
                {32'h0, 32'h22222222}, 3,
                0, 0, 11'h0, 4'h0, 32'h0,
                3'd0, 2'd0, 16'h0, 8'h0, 7'h0);
    tv[5] = mkv(hdr(2'b00, 5'b00100, 3'd0, 1'b0, 2'd0, 10'd1,
                    16'h0, 8'h0, 4'hF),
                {32'h0, 32'h0000_0010}, 64'h0, 2,
                0, 0, 11'h0, 4'h0, 32'h0,
                3'd0, 2'd0, 16'h0, 8'h0, 7'h0);
    tv[6] = mkv(hdr(2'b10, 5'd0, 3'd0, 1'b1, 2'd0, 10'd1,
                    16'h0, 8'h0, 4'hF),
                {32'h33333333, 32'h0000_0020}, 64'h0, 2,
                0, 0, 11'h0, 4'h0, 32'h0,
                3'd0, 2'd0, 16'h0, 8'h0, 7'h0);
    tv[7] = mkv(hdr(2'b10, 5'd0, 3'd0, 1'b0, 2'd0, 10'd1,
                    16'h0, 8'h0, 4'hF),
                64'h0, 64'h0, 1,
                0, 0, 11'h0, 4'h0, 32'h0,
                3'd0, 2'd0, 16'h0, 8'h0, 7'h0);
    tv[8] = mkv(hdr(2'b11, 5'd0, 3'd0, 1'b0, 2'd0, 10'd1,
                    16'h0, 8'h0, 4'hF),
                {32'h0000_0040, 32'h0}, 64'h0, 2,
                0, 0, 11'h0, 4'h0, 32'h0,
                3'd0, 2'd0, 16'h0, 8'h0, 7'h0);
    tv[9] = mkv(hdr(2'b10, 5'd0, 3'd0, 1'b0, 2'd0, 10'd1,
                    16'h0, 8'h0, 4'h1),
                {32'h12345678, 32'hFFFF_FFFC}, 64'h0, 2,
                1, 0, 11'h7FF, 4'h1, 32'h12345678,
                3'd0, 2'd0, 16'h0, 8'h0, 7'h0);

    repeat (3) @(negedge i_clk);
    chk("rst_tready", o_rx_tready, 1'b0);
    chk("rst_wr_en", o_wr_en, 1'b0);
    chk("rst_compl", o_req_compl, 1'b0);
    chk("rst_outs", {o_wr_addr, o_wr_be, o_wr_data, o_rd_addr,
                     o_rd_be, o_req_tc, o_req_attr, o_req_rid,
                     o_req_tag, o_req_laddr}, 64'h0);
    i_nrst = 1'b1;
    @(negedge i_clk);
    chk("post_rst_tready", o_rx_tready, 1'b1);

    for (int i = 0; i < 10; i++) run_vec(tv[i]);

    // reset while waiting for the completion
    rd_q.push_back(tv[1]);
    send_beat(tv[1].b[0], 1'b0);
    send_beat(tv[1].b[1], 1'b1);
    chk("rst_cpl_compl_up", o_req_compl, 1'b1);
    repeat (3) @(negedge i_clk);
    #2 i_nrst = 1'b0;
    #1;
    chk("rst_cpl_compl_drop", o_req_compl, 1'b0);
    chk("rst_cpl_tready", o_rx_tready, 1'b0);
    @(negedge i_clk);
    i_nrst = 1'b1;
    @(negedge i_clk);
    chk("rst_cpl_idle_tready", o_rx_tready, 1'b1);
    run_vec(tv[1]);
    run_vec(tv[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
